lif_layer_sequencer: RTL
========================

Name: lif_layer_sequencer

Overview:
- Time-multiplexes one shared LIF update datapath across NUM_NEURONS neurons of a layer.
- Membrane potentials live in an internal register file.
- On each timestep tick, the block walks the neurons one per clock, applies leak, integration, threshold and reset, and then publishes the layer's spike vector.
- Replaces one-instance-per-neuron layers. The next layer's currents are driven from spike_out.

Parameters:
NUM_NEURONS, 4, number of neurons sharing the datapath (2..16)
W_IN, 4, input current width per neuron (unsigned)
W_STATE, 8, membrane potential width (unsigned)
LEAK_SHIFT, 1, leak as right shift of potential per timestep (0 = no leak)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset: asynchronous, active-high; clears all state
tick  in  1  start a timestep; sampled only in IDLE
clear  in  1  zero all potentials; sampled only in IDLE
threshold  in  W_STATE  firing threshold; sampled once per neuron update
currents  in  NUM_NEURONS*W_IN  packed currents, neuron i at [i*W_IN +: W_IN]; captured on tick acceptance
busy  out  1  high while a timestep is in progress
done  out  1  one-cycle pulse when spike_out updates
spike_out  out  NUM_NEURONS  registered spikes of the last completed timestep; held until the next done
tick_overrun  out  1  one-cycle pulse when tick arrives while busy, or is dropped due to clear
mem_sel  in  $clog2(NUM_NEURONS)  potential readout select
mem_out  out  W_STATE  combinational read of potential[mem_sel]; out-of-range select returns 0

Behaviour:
- Reset (rst=1, any time, including mid-timestep):
  - state = IDLE, all potentials = 0.
  - busy = 0, done = 0, spike_out = 0, tick_overrun = 0.
  - Neuron index and captured currents are cleared.
- FSM states:
  - IDLE: accepts tick and clear.
    - clear=1: all potentials zeroed at the next edge. clear has priority; a simultaneous tick is dropped and pulses tick_overrun.
    - tick=1, clear=0: capture currents into a shadow register, index = 0, go to UPDATE.
  - UPDATE: one neuron per cycle, index 0..NUM_NEURONS-1.
    - sum = (v[i] >> LEAK_SHIFT) + I[i], computed at W_STATE+1 bits, saturated to 2^W_STATE-1.
    - If sum >= threshold: spike_next[i] = 1 and v[i] = 0.
    - Else: spike_next[i] = 0 and v[i] = sum.
    - After index NUM_NEURONS-1, go to DONE.
  - DONE: spike_out <= spike_next, done = 1 for this cycle, then IDLE.
- Timing: tick sampled at edge 0 → UPDATE cycles 1..NUM_NEURONS → done and new spike_out visible in cycle NUM_NEURONS+1.
  - busy is high in cycles 1..NUM_NEURONS+1 and low in IDLE.
  - Back-to-back ticks: a tick held high during the DONE cycle is ignored and pulses overrun. Earliest next accepted tick is cycle NUM_NEURONS+2 (period NUM_NEURONS+2).
- tick or clear while busy: both are ignored; tick additionally pulses tick_overrun the following cycle. Potentials are unaffected.
- Input stability:
  - currents changing during UPDATE has no effect, since the shadow copy is used.
  - threshold is read live each UPDATE cycle; it must be held stable across a timestep for defined results.
- threshold = 0: every neuron spikes every timestep, and potentials stay 0.
- Saturation: sum clamps at 2^W_STATE-1 and fires if threshold <= that value. threshold = 2^W_STATE-1 fires only at saturation.
- mem_out reflects the register file, so a neuron's new value is readable the cycle after its UPDATE cycle.

Test Plan:
- Reset mid-UPDATE: with v all nonzero, assert rst at UPDATE index 2 → next cycle busy=0, spike_out=0, mem_out=0 for all sel; a subsequent tick runs a normal timestep.
- Params 4/4/8/1, threshold=20, all currents=15, five ticks:
  - v after each timestep: 15, 0(spike), 15, 0(spike), 15.
  - spike_out after each timestep: 0000, 1111, 0000, 1111, 0000.
  - done exactly 5 cycles after each accepted tick.
- Per-neuron independence: currents {n3=0, n2=5, n1=10, n0=15}, threshold=20, 2 ticks:
  - Timestep 1 v: 0/5/10/15, spike_out 0000.
  - Timestep 2 sums: 0, 7, 15, 22 → spike_out=0001; v = 0/7/15/0.
- Saturation: LEAK_SHIFT=0, threshold=255, current 15 on neuron 0 only:
  - Spike on timestep 17 (16*15=240, 240+15=255).
  - Threshold 250 → spike on timestep 17 (255 ≥ 250); none earlier.
- Overrun and clear priority:
  - tick held high continuously → accepted every 6 cycles, tick_overrun pulses on the other cycles, spikes correct.
  - clear+tick together in IDLE → potentials 0, no done, tick_overrun=1.
- threshold=0 with arbitrary currents → spike_out=1111 every timestep, mem_out=0 for every neuron.

Source files
------------

// File: rtl/lif_layer_sequencer_if.sv
// Bus bundle for the LIF layer sequencer: timestep control, currents, spikes and
// potential readout. The sequencer takes the slave side.
interface lif_layer_sequencer_if #(
   parameter int NUM_NEURONS = 4,
   parameter int W_IN        = 4,
   parameter int W_STATE     = 8
) ();
   localparam int SEL_W = $clog2(NUM_NEURONS);

   logic                        tick;
   logic                        clear;
   logic [W_STATE-1:0]          threshold;
   logic [NUM_NEURONS*W_IN-1:0] currents;
   logic                        busy;
   logic                        done;
   logic [NUM_NEURONS-1:0]      spike_out;
   logic                        tick_overrun;
   logic [SEL_W-1:0]            mem_sel;
   logic [W_STATE-1:0]          mem_out;

   modport master (
      output tick, clear, threshold, currents, mem_sel,
      input  busy, done, spike_out, tick_overrun, mem_out
   );

   modport slave (
      input  tick, clear, threshold, currents, mem_sel,
      output busy, done, spike_out, tick_overrun, mem_out
   );
endinterface

// File: rtl/lif_layer_sequencer.sv
// One shared leaky-integrate-and-fire datapath walked across all neurons of a
// layer, one neuron per clock, with potentials held in a local register file.
module lif_layer_sequencer #(
   parameter int NUM_NEURONS = 4,
   parameter int W_IN        = 4,
   parameter int W_STATE     = 8,
   parameter int LEAK_SHIFT  = 1
) (
   input logic                  clk,
   input logic                  rst,
   lif_layer_sequencer_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_NEURONS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UPDATE = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]                  state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [NUM_NEURONS*W_IN-1:0] cur_q, cur_d;
   logic [NUM_NEURONS-1:0]      spk_nxt_q, spk_nxt_d;
   logic [NUM_NEURONS-1:0]      spike_q, spike_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        ovr_q, ovr_d;
   logic [W_STATE-1:0]          pot_q [NUM_NEURONS];

   logic                        pot_we_s;
   logic                        pot_clr_s;
   logic [W_STATE-1:0]          pot_wdata_s;
   logic [W_IN-1:0]             cur_s;
   logic [W_STATE:0]            sum_s;
   logic [W_STATE-1:0]          sat_s;
   logic                        fire_s;
   logic                        last_s;

   // Leak, integrate and saturate the neuron selected by the walk index.
   always_comb begin
      cur_s  = cur_q[idx_q*W_IN +: W_IN];
      sum_s  = {1'b0, pot_q[idx_q] >> LEAK_SHIFT} + (W_STATE+1)'(cur_s);
      sat_s  = sum_s[W_STATE] ? {W_STATE{1'b1}} : sum_s[W_STATE-1:0];
      fire_s = (sat_s >= bus.threshold);
      last_s = (idx_q == IDX_W'(NUM_NEURONS-1));
   end

   // Sequencer next state; clear wins over tick, and control is ignored while busy.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      spk_nxt_d   = spk_nxt_q;
      spike_d     = spike_q;
      ovr_d       = 1'b0;
      pot_we_s    = 1'b0;
      pot_clr_s   = 1'b0;
      pot_wdata_s = fire_s ? {W_STATE{1'b0}} : sat_s;
      case (state_q)
         S_IDLE: begin
            if (bus.clear) begin
               pot_clr_s = 1'b1;
               ovr_d     = bus.tick;
            end else if (bus.tick) begin
               cur_d   = bus.currents;
               idx_d   = {IDX_W{1'b0}};
               state_d = S_UPDATE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UPDATE: begin
            pot_we_s         = 1'b1;
            ovr_d            = bus.tick;
            spk_nxt_d[idx_q] = fire_s;
            if (last_s) begin
               spike_d = spk_nxt_d;
               idx_d   = {IDX_W{1'b0}};
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            ovr_d   = bus.tick;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= {IDX_W{1'b0}};
         cur_q     <= {(NUM_NEURONS*W_IN){1'b0}};
         spk_nxt_q <= {NUM_NEURONS{1'b0}};
         spike_q   <= {NUM_NEURONS{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cur_q     <= cur_d;
         spk_nxt_q <= spk_nxt_d;
         spike_q   <= spike_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
      end
   end

   // Membrane potential register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= {W_STATE{1'b0}};
      end else if (pot_clr_s) begin
         for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= {W_STATE{1'b0}};
      end else if (pot_we_s) begin
         pot_q[idx_q] <= pot_wdata_s;
      end else begin
         pot_q[idx_q] <= pot_q[idx_q];
      end
   end

   // Readout port; selects beyond the last neuron read as zero.
   always_comb begin
      if ({1'b0, bus.mem_sel} < (IDX_W+1)'(NUM_NEURONS)) begin
         bus.mem_out = pot_q[bus.mem_sel];
      end else begin
         bus.mem_out = {W_STATE{1'b0}};
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.spike_out    = spike_q;
   assign bus.tick_overrun = ovr_q;
endmodule
